// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: drains a normal-mode (non show-ahead) byte FIFO and packs
// BYTES_PER_WORD bytes into one output word. A partial word is flushed after
// FLUSH_TIMEOUT consecutive idle cycles.
// Build option: define PACK_MSB_FIRST_EN to pack the first byte into the top
// lane and fill downward. By default the first byte lands in out_data[7:0]
// and the word fills upward.
//
// Output handshake: a word transfers on every rdclk edge where
// out_valid && out_ready. While out_valid is high, out_data and out_bytes
// hold steady until that edge. out_ready has no effect while out_valid is low.
module fifo_rd_packer #(
  parameter int BYTES_PER_WORD = 4,
  parameter int FLUSH_TIMEOUT  = 16,
  localparam int CW            = $clog2(BYTES_PER_WORD) + 1
) (
  input  logic                        rdclk,
  input  logic                        rst_n,
  input  logic                        rdempty,
  input  logic [7:0]                  q,
  output logic                        rdreq,
  output logic [8*BYTES_PER_WORD-1:0] out_data,
  output logic [CW-1:0]               out_bytes,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        dbg_state
);

  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t      state;
  logic [CW-1:0] cnt;       // bytes captured into the current word
  logic        inflight;    // rdreq was high last cycle, so q carries a byte now
  logic [7:0]  idle_cnt;    // consecutive idle cycles while holding a partial word
  logic        fill_ok;
  logic        idle_cyc;

  // Room check counts the byte already requested but not yet captured.
  assign fill_ok  = (int'(cnt) + int'(inflight)) < BYTES_PER_WORD;

  // Reads are issued only while collecting, never into an empty FIFO, and
  // never during reset.
  assign rdreq    = rst_n && (state == COLLECT) && !rdempty && fill_ok;

  // Idle means a partial word is held, nothing is in flight and the FIFO is dry.
  assign idle_cyc = (state == COLLECT) && (cnt != '0) && !inflight && rdempty;

  assign dbg_state = state;

  // Byte lane that receives the byte with capture index c.
  function automatic int lane_of(input logic [CW-1:0] c);
`ifdef PACK_MSB_FIRST_EN
    return BYTES_PER_WORD - 1 - int'(c);
`else
    return int'(c);
`endif
  endfunction

  // Packing FSM: capture bytes, present full or flushed words, and wait for acceptance.
  always_ff @(posedge rdclk) begin
    if (!rst_n) begin
      state     <= COLLECT;
      cnt       <= '0;
      inflight  <= 1'b0;
      idle_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_bytes <= '0;
    end else begin
      inflight <= rdreq;
      case (state)
        COLLECT: begin
          if (inflight) begin
            // Unused lanes are already zero because the word is cleared on
            // acceptance and on reset.
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
              if (lane_of(cnt) == i) out_data[8*i +: 8] <= q;
            end
            cnt      <= cnt + CW'(1);
            idle_cnt <= '0;
            if (int'(cnt) == BYTES_PER_WORD - 1) begin
              state     <= PRESENT;
              out_valid <= 1'b1;
              out_bytes <= CW'(BYTES_PER_WORD);
            end
          end else if (idle_cyc) begin
            if (idle_cnt == 8'(FLUSH_TIMEOUT - 1)) begin
              state     <= PRESENT;
              out_valid <= 1'b1;
              out_bytes <= cnt;
              idle_cnt  <= '0;
            end else begin
              idle_cnt <= idle_cnt + 8'd1;
            end
          end else begin
            idle_cnt <= '0;
          end
        end
        PRESENT: begin
          idle_cnt <= '0;
          if (out_ready) begin
            state     <= COLLECT;
            out_valid <= 1'b0;
            out_bytes <= '0;
            out_data  <= '0;
            cnt       <= '0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: directed bench for fifo_rd_packer with default parameters
// (4 bytes per word, flush after 16 idle cycles). It models a normal-mode FIFO
// that returns data one cycle after rdreq. Expected words follow the packing
// order selected by PACK_MSB_FIRST_EN.
module tb_fifo_rd_packer;

  // Clock and reset.
  logic        rdclk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 rdclk = ~rdclk;

  logic        rdempty = 1'b1;
  logic [7:0]  q = 8'h00;
  logic        rdreq;
  logic [31:0] out_data;
  logic [2:0]  out_bytes;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        dbg_state;

  fifo_rd_packer #(.BYTES_PER_WORD(4), .FLUSH_TIMEOUT(16)) dut (
    .rdclk     (rdclk),
    .rst_n     (rst_n),
    .rdempty   (rdempty),
    .q         (q),
    .rdreq     (rdreq),
    .out_data  (out_data),
    .out_bytes (out_bytes),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dbg_state (dbg_state)
  );

`ifdef PACK_MSB_FIRST_EN
  localparam logic [31:0] E_W1 = 32'h01020304, E_W2 = 32'h05060708;
  localparam logic [31:0] E_F1 = 32'h11223300, E_S1 = 32'h51525354;
  localparam logic [31:0] E_S2 = 32'h55000000, E_R1 = 32'h34414243;
  localparam logic [31:0] E_A  = 32'hA1A2A3A4, E_B  = 32'hB1B20000;
  localparam logic [31:0] E_T1 = 32'h71727374, E_T2 = 32'h75767778;
`else
  localparam logic [31:0] E_W1 = 32'h04030201, E_W2 = 32'h08070605;
  localparam logic [31:0] E_F1 = 32'h00332211, E_S1 = 32'h54535251;
  localparam logic [31:0] E_S2 = 32'h00000055, E_R1 = 32'h43424134;
  localparam logic [31:0] E_A  = 32'hA4A3A2A1, E_B  = 32'h0000B2B1;
  localparam logic [31:0] E_T1 = 32'h74737271, E_T2 = 32'h78777675;
`endif

  // FIFO model: rdreq is sampled at the edge. Data and the empty flag change
  // 1 time unit later, and q holds its value between reads.
  logic [7:0] fifo[$];
  logic       tog_en = 1'b0;
  logic       mask   = 1'b0;
  logic       req_s;
  int         viol   = 0;

  always @(posedge rdclk) begin
    req_s = rdreq;
    #1;
    if (req_s) begin
      if (fifo.size() > 0) q = fifo.pop_front();
      else viol++;
    end
    if (tog_en) mask = ~mask;
    else mask = 1'b0;
    rdempty = (fifo.size() == 0) || mask;
  end

  // rdreq must stay low during reset, on an empty FIFO, and while a word is held.
  always @(negedge rdclk) begin
    if (rdreq && (!rst_n || rdempty || out_valid)) viol++;
  end

  // Scoreboard counters and checks.
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
  endtask

  // Wait on negedges until out_valid is seen or the budget expires. n returns the number of negedges waited.
  task automatic wait_valid(input string tag, input int max, output int n);
    n = 0;
    do begin
      @(negedge rdclk);
      n++;
    end while (!out_valid && n < max);
    chk({tag, "_valid"}, out_valid, 1'b1);
  endtask

  int         n;
  int         stable;
  int         req_hi;
  logic [5:0] pat;

  initial begin
    // Reset state.
    repeat (3) @(negedge rdclk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data",  out_data, 32'h0);
    chk("rst_bytes", out_bytes, 3'd0);
    chk("rst_rdreq", rdreq, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge rdclk);

    // Bytes 0x01..0x08 with out_ready high: rdreq stays high for four cycles,
    // then the first word is presented.
    for (int i = 1; i <= 8; i++) push(8'(i));
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge rdclk);
      pat = {pat[4:0], rdreq};
    end
    chk("w1_rdreq_pattern", pat, 6'b111100);
    chk("w1_valid", out_valid, 1'b1);
    chk("w1_data",  out_data, E_W1);
    chk("w1_bytes", out_bytes, 3'd4);
    wait_valid("w2", 20, n);
    chk("w2_data",  out_data, E_W2);
    chk("w2_bytes", out_bytes, 3'd4);
    repeat (2) @(negedge rdclk);

    // Three bytes followed by an empty FIFO: the flush comes 16 idle cycles after the last capture.
    push(8'h11); push(8'h22); push(8'h33);
    wait_valid("f1", 40, n);
    chk("f1_latency", n, 21);
    chk("f1_data",  out_data, E_F1);
    chk("f1_bytes", out_bytes, 3'd3);
    repeat (2) @(negedge rdclk);

    // Downstream stall of 10 cycles: the word holds and rdreq stays low.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'h51 + 8'(i));
    wait_valid("s1", 20, n);
    stable = 0;
    req_hi = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge rdclk);
      if (out_valid === 1'b1 && out_data === E_S1 && out_bytes === 3'd4) stable++;
      if (rdreq !== 1'b0) req_hi++;
    end
    chk("s1_stable_cycles", stable, 10);
    chk("s1_rdreq_high",    req_hi, 0);
    out_ready = 1'b1;
    @(negedge rdclk);
    chk("s1_released", out_valid, 1'b0);
    // The leftover byte 0x55 is flushed on its own.
    wait_valid("s2", 40, n);
    chk("s2_data",  out_data, E_S2);
    chk("s2_bytes", out_bytes, 3'd1);
    repeat (2) @(negedge rdclk);

    // Reset after two of four bytes are captured. The third byte is still in
    // flight and is dropped. 0x34 is still in the FIFO and starts the next word.
    push(8'h31); push(8'h32); push(8'h33); push(8'h34);
    repeat (4) @(negedge rdclk);
    rst_n = 1'b0;
    @(negedge rdclk);
    chk("r_valid", out_valid, 1'b0);
    chk("r_bytes", out_bytes, 3'd0);
    rst_n = 1'b1;
    push(8'h41); push(8'h42); push(8'h43);
    wait_valid("r1", 20, n);
    chk("r1_data",  out_data, E_R1);
    chk("r1_bytes", out_bytes, 3'd4);
    repeat (2) @(negedge rdclk);

    // Reset while a word is presented: the word is discarded.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'h61 + 8'(i));
    wait_valid("p1", 20, n);
    rst_n = 1'b0;
    @(negedge rdclk);
    rst_n = 1'b1;
    chk("p_valid", out_valid, 1'b0);
    chk("p_data",  out_data, 32'h0);
    out_ready = 1'b1;
    repeat (2) @(negedge rdclk);

    // Lane order for a full word and for a two-byte flush.
    for (int i = 0; i < 4; i++) push(8'hA1 + 8'(i));
    wait_valid("a", 20, n);
    chk("a_data", out_data, E_A);
    repeat (2) @(negedge rdclk);
    push(8'hB1); push(8'hB2);
    wait_valid("b", 40, n);
    chk("b_data",  out_data, E_B);
    chk("b_bytes", out_bytes, 3'd2);
    repeat (2) @(negedge rdclk);

    // rdempty toggles every cycle: no byte is lost or duplicated.
    tog_en = 1'b1;
    for (int i = 0; i < 8; i++) push(8'h71 + 8'(i));
    wait_valid("t1", 40, n);
    chk("t1_data", out_data, E_T1);
    wait_valid("t2", 40, n);
    chk("t2_data", out_data, E_T2);
    tog_en = 1'b0;
    repeat (3) @(negedge rdclk);
    chk("fifo_drained", fifo.size(), 0);

    chk("no_illegal_rdreq", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
